regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
Shares the regfile's single read port and single write port among NREQ requesters. Reads and writes are arbitrated independently, each with its own round-robin scheduler. The block issues the winning read and write onto the regfile in the same cycle and routes the read data back to the requester that issued the read. It sits between the requesters and the regfile instance and is the only driver of the regfile's R_* and W_* inputs.

Parameters:
N, 16, number of regfile entries; AW = $clog2(N)
WIDTH, 8, data width
NREQ, 4, number of requesters (power of 2, >= 2)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  request pending, one bit per requester
req_we  in  NREQ  1 = write request, 0 = read request
req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
req_wdata  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
req_ready  out  NREQ  one-hot-per-class grant; the request transfers when valid & ready
resp_valid  out  NREQ  one-hot; read data for requester i is valid this cycle
resp_rdata  out  WIDTH  read data, shared by all requesters
rf_R_en  out  1  regfile read enable
rf_R_addr  out  AW  regfile read address
rf_R_data  in  WIDTH  regfile read data, valid the cycle after rf_R_en is sampled
rf_W_en  out  1  regfile write enable
rf_W_addr  out  AW  regfile write address
rf_W_data  out  WIDTH  regfile write data

Behaviour:
- Request classes:
  - rd_req = req_valid & ~req_we
  - wr_req = req_valid & req_we
- Arbitration per class:
  - Round-robin with a pointer (rd_ptr or wr_ptr, AW-independent, clog2(NREQ) bits).
  - The grant goes to the first requesting index at or after the pointer, wrapping modulo NREQ.
  - On a grant to index g, the pointer becomes (g+1) mod NREQ.
  - With no grant, the pointer holds.
- Grant outputs:
  - req_ready = rd_gnt | wr_gnt.
  - req_ready is combinational from req_valid and the pointers.
  - Requesters must hold addr, wdata and we stable while valid and not ready.
- Regfile drive (combinational from the grants):
  - rf_R_en = |rd_gnt and rf_R_addr = granted address.
  - rf_W_en = |wr_gnt; rf_W_addr and rf_W_data come from the granted requester.
  - With no grant in a class, the enable is 0 and the address/data are driven to 0.
- Read response, 1-cycle latency:
  - Register rsp_id (one-hot), rsp_pend, and the bypass flag and data.
  - The cycle after a read grant: resp_valid = registered one-hot id and resp_rdata = rf_R_data.
  - Otherwise resp_valid = 0 and resp_rdata = 0.
  - Back-to-back reads are supported at one per cycle.
- Read-after-write in the same cycle: if both grants fire with rf_R_addr == rf_W_addr, the response returns the new write data (write-first). The bypass data is registered, and resp_rdata selects it instead of rf_R_data.
- Write-then-read on the next cycle needs no special handling; the regfile returns the stored value.
- Reset (async assert, sync deassert assumed upstream):
  - Pointers go to 0, so requester 0 has first priority.
  - rsp_pend = 0 and bypass flag = 0, so resp_valid = 0 and resp_rdata = 0.
  - If reset asserts while a read is pending, the response is dropped and never delivered.
- Boundaries:
  - The pointer wraps from NREQ-1 to 0.
  - A single requester that asserts continuously is granted every cycle.
  - If all requesters are valid, each is granted once per NREQ cycles in its class.
  - No grant is ever issued to a requester whose valid is low.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - AW derivation
  - NREQ-dependent id width
  - resp_sel encodings (REGFILE vs BYPASS)
- Sub-module rr_arbiter #(NREQ), instantiated twice (read and write):
  - Inputs: clk, rst_n, req[NREQ].
  - Outputs: gnt[NREQ] (one-hot, combinational) and the internal pointer register.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0000 is not required, but resp_valid=0000, resp_rdata=0, rf_R_en=0 and rf_W_en=0 during reset. After release, the first read grant goes to requester 0.
- Write then read:
  - Req1 writes addr 5 = 8'hA5 -> rf_W_en=1, rf_W_addr=5, rf_W_data=A5 in the same cycle.
  - Next cycle, req2 reads addr 5 -> the cycle after, resp_valid=0100 and resp_rdata=A5.
- Round-robin fairness: all 4 requesters read continuously at addresses 0..3 -> grant order 0,1,2,3,0. Each resp_valid matches the grant one cycle later, and the data equals the preloaded contents.
- Concurrent read and write: req0 reads addr 7 while req3 writes addr 9 = 8'h3C in the same cycle -> both ready. Next cycle, resp_valid=0001 with the old mem[7], and mem[9]=3C.
- Same-address bypass: req0 reads addr 4 while req1 writes addr 4 = 8'h5A in the same cycle -> next cycle resp_valid=0001 and resp_rdata=5A.
- Reset mid-read: grant a read at cycle t and assert rst_n=0 before t+1 -> no resp_valid pulse. After release, the pointers are 0.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared sizing helpers and encodings for the regfile port arbiter slice.
package regfile_ctrl_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Address width of a regfile with n_entries entries.
  function automatic int unsigned addr_width(input int unsigned n_entries);
    return clog2_min1(n_entries);
  endfunction

  // Width of a requester index / round-robin pointer.
  function automatic int unsigned id_width(input int unsigned nreq);
    return clog2_min1(nreq);
  endfunction

  typedef enum logic {
    RSEL_REGFILE = 1'b0,
    RSEL_BYPASS  = 1'b1
  } resp_sel_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   ptr
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // NREQ is a power of two, so PW-bit addition wraps modulo NREQ.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    if (rst_n) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = ptr_q + PW'(k);
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the regfile's single read and write ports among NREQ requesters,
// with a registered one-cycle read response and same-cycle write-first bypass.
module regfile_port_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter  int unsigned N     = 16,
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned AW    = addr_width(N),
  localparam int unsigned IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  rf_R_en,
  output logic [AW-1:0]         rf_R_addr,
  input  logic [WIDTH-1:0]      rf_R_data,
  output logic                  rf_W_en,
  output logic [AW-1:0]         rf_W_addr,
  output logic [WIDTH-1:0]      rf_W_data
);

  logic [NREQ-1:0] rd_req, wr_req;
  logic [NREQ-1:0] rd_gnt, wr_gnt;
  logic [IDW-1:0]  rd_ptr, wr_ptr;
  logic            bypass_hit;

  logic [NREQ-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_pend_q, rsp_pend_d;
  resp_sel_e        rsp_sel_q, rsp_sel_d;
  logic [WIDTH-1:0] byp_data_q, byp_data_d;

  assign rd_req = req_valid & ~req_we;
  assign wr_req = req_valid & req_we;

  rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .gnt   (rd_gnt),
    .ptr   (rd_ptr)
  );

  rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .gnt   (wr_gnt),
    .ptr   (wr_ptr)
  );

  logic unused_ptrs;
  assign unused_ptrs = ^{rd_ptr, wr_ptr};

  assign req_ready = rd_gnt | wr_gnt;
  assign rf_R_en   = |rd_gnt;
  assign rf_W_en   = |wr_gnt;

  // Grants are one-hot, so the muxes leave fields at zero when a class is idle.
  always_comb begin
    rf_R_addr = '0;
    rf_W_addr = '0;
    rf_W_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rd_gnt[i]) rf_R_addr = req_addr[i*AW +: AW];
      if (wr_gnt[i]) begin
        rf_W_addr = req_addr[i*AW +: AW];
        rf_W_data = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bypass_hit = rf_R_en && rf_W_en && (rf_R_addr == rf_W_addr);

  always_comb begin
    rsp_pend_d = rf_R_en;
    rsp_id_d   = rd_gnt;
    rsp_sel_d  = bypass_hit ? RSEL_BYPASS : RSEL_REGFILE;
    byp_data_d = bypass_hit ? rf_W_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= '0;
      rsp_sel_q  <= RSEL_REGFILE;
      byp_data_q <= '0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sel_q  <= rsp_sel_d;
      byp_data_q <= byp_data_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (rsp_pend_q) begin
      resp_valid = rsp_id_q;
      resp_rdata = (rsp_sel_q == RSEL_BYPASS) ? byp_data_q : rf_R_data;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural read-first regfile.
module tb_regfile_port_arbiter;

  localparam int unsigned N = 16, WIDTH = 8, NREQ = 4, AW = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid, req_we, req_ready, resp_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0]      resp_rdata, rf_R_data, rf_W_data;
  logic                  rf_R_en, rf_W_en;
  logic [AW-1:0]         rf_R_addr, rf_W_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.N(N), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .rf_R_en    (rf_R_en),
    .rf_R_addr  (rf_R_addr),
    .rf_R_data  (rf_R_data),
    .rf_W_en    (rf_W_en),
    .rf_W_addr  (rf_W_addr),
    .rf_W_data  (rf_W_data)
  );

  // Read-first regfile: preloaded with 8'h80+i while reset is held.
  logic [WIDTH-1:0] mem [N];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= 8'h80 + 8'(i);
    end else begin
      if (rf_R_en) rf_R_data <= mem[rf_R_addr];
      if (rf_W_en) mem[rf_W_addr] <= rf_W_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  v;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  rdy;
    logic        ren;
    logic [3:0]  raddr;
    logic        wen;
    logic [3:0]  waddr;
    logic [7:0]  wdat;
    logic [3:0]  rv;
    logic [7:0]  rd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             v        we       addr      wd            rdy     ren  ra    wen  wa    wdat   rv       rd
    vecs[0]  = '{4'b0010, 4'b0010, 16'h0050, 32'h0000A500, 4'b0010, 1'b0, 4'h0, 1'b1, 4'h5, 8'hA5, 4'b0000, 8'h00};
    vecs[1]  = '{4'b0100, 4'b0000, 16'h0500, 32'h00000000, 4'b0100, 1'b1, 4'h5, 1'b0, 4'h0, 8'h00, 4'b0000, 8'h00};
    vecs[2]  = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 4'b0100, 8'hA5};
    vecs[3]  = '{4'b1111, 4'b0000, 16'h3210, 32'h00000000, 4'b1000, 1'b1, 4'h3, 1'b0, 4'h0, 8'h00, 4'b0000, 8'h00};
    vecs[4]  = '{4'b1111, 4'b0000, 16'h3210, 32'h00000000, 4'b0001, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 4'b1000, 8'h83};
    vecs[5]  = '{4'b1111, 4'b0000, 16'h3210, 32'h00000000, 4'b0010, 1'b1, 4'h1, 1'b0, 4'h0, 8'h00, 4'b0001, 8'h80};
    vecs[6]  = '{4'b1111, 4'b0000, 16'h3210, 32'h00000000, 4'b0100, 1'b1, 4'h2, 1'b0, 4'h0, 8'h00, 4'b0010, 8'h81};
    vecs[7]  = '{4'b1111, 4'b0000, 16'h3210, 32'h00000000, 4'b1000, 1'b1, 4'h3, 1'b0, 4'h0, 8'h00, 4'b0100, 8'h82};
    vecs[8]  = '{4'b1001, 4'b1000, 16'h9007, 32'h3C000000, 4'b1001, 1'b1, 4'h7, 1'b1, 4'h9, 8'h3C, 4'b1000, 8'h83};
    vecs[9]  = '{4'b0011, 4'b0010, 16'h0044, 32'h00005A00, 4'b0011, 1'b1, 4'h4, 1'b1, 4'h4, 8'h5A, 4'b0001, 8'h87};
    vecs[10] = '{4'b0100, 4'b0000, 16'h0900, 32'h00000000, 4'b0100, 1'b1, 4'h9, 1'b0, 4'h0, 8'h00, 4'b0001, 8'h5A};
    vecs[11] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 4'b0100, 8'h3C};
    vecs[12] = '{4'b0010, 4'b0000, 16'h0040, 32'h00000000, 4'b0010, 1'b1, 4'h4, 1'b0, 4'h0, 8'h00, 4'b0000, 8'h00};
    vecs[13] = '{4'b0010, 4'b0000, 16'h0040, 32'h00000000, 4'b0010, 1'b1, 4'h4, 1'b0, 4'h0, 8'h00, 4'b0010, 8'h5A};
    vecs[14] = '{4'b0010, 4'b0000, 16'h0040, 32'h00000000, 4'b0010, 1'b1, 4'h4, 1'b0, 4'h0, 8'h00, 4'b0010, 8'h5A};
    vecs[15] = '{4'b0101, 4'b0101, 16'h0B0A, 32'h00220011, 4'b0100, 1'b0, 4'h0, 1'b1, 4'hB, 8'h22, 4'b0010, 8'h5A};
    vecs[16] = '{4'b0101, 4'b0101, 16'h0B0A, 32'h00220011, 4'b0001, 1'b0, 4'h0, 1'b1, 4'hA, 8'h11, 4'b0000, 8'h00};
    vecs[17] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 4'b0000, 8'h00};

    // Reset held with every requester reading.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_we    = 4'b0000;
    req_addr  = 16'h3210;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst resp_rdata", 32'(resp_rdata), 32'h0);
    chk("rst rf_R_en",    32'(rf_R_en),    32'h0);
    chk("rst rf_W_en",    32'(rf_W_en),    32'h0);

    // Release: first read grant goes to requester 0.
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first ready",  32'(req_ready), 32'b0001);
    chk("first R_addr", 32'(rf_R_addr), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("first resp_valid", 32'(resp_valid), 32'b0001);
    chk("first resp_rdata", 32'(resp_rdata), 32'h80);
    chk("second ready",     32'(req_ready),  32'b0010);

    // Reset lands while the grant to requester 1 is pending: response dropped.
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst resp_valid", 32'(resp_valid), 32'h0);
    chk("midrst resp_rdata", 32'(resp_rdata), 32'h0);
    chk("midrst rf_R_en",    32'(rf_R_en),    32'h0);
    @(posedge clk); #1;
    req_we = 4'b1010;
    rst_n  = 1'b1;
    @(negedge clk);
    chk("postrst ready",      32'(req_ready),  32'b0011);
    chk("postrst resp_valid", 32'(resp_valid), 32'h0);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst idle resp_valid", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      req_valid = vecs[i].v;
      req_we    = vecs[i].we;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wd;
      @(negedge clk);
      chk($sformatf("v%0d ready", i),      32'(req_ready),  32'(vecs[i].rdy));
      chk($sformatf("v%0d R_en", i),       32'(rf_R_en),    32'(vecs[i].ren));
      chk($sformatf("v%0d R_addr", i),     32'(rf_R_addr),  32'(vecs[i].raddr));
      chk($sformatf("v%0d W_en", i),       32'(rf_W_en),    32'(vecs[i].wen));
      chk($sformatf("v%0d W_addr", i),     32'(rf_W_addr),  32'(vecs[i].waddr));
      chk($sformatf("v%0d W_data", i),     32'(rf_W_data),  32'(vecs[i].wdat));
      chk($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d resp_rdata", i), 32'(resp_rdata), 32'(vecs[i].rd));
      @(posedge clk); #1;
    end

    chk("mem9 after write",  32'(mem[9]),  32'h3C);
    chk("mem4 after bypass", 32'(mem[4]),  32'h5A);
    chk("mem11 after write", 32'(mem[11]), 32'h22);
    chk("mem10 after write", 32'(mem[10]), 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
